fifo_ptr_sync_status: RTL and testbench
=======================================

Name: fifo_ptr_sync_status

Overview:
Receiving end of the gray-coded pointer crossing in the async FIFO. Synchronises the opposite domain's gray pointer into the local clock, decodes it to binary and compares it with the local next pointer. Produces registered full/empty, almost flags and a fill level. One instance sits in the write domain (full side) and one in the read domain (empty side). Each instance feeds its flag back to that domain's gray pointer counter.

Parameters:
n, 4, pointer width including wrap bit; FIFO depth = 2^(n-1)
SYNC_STAGES, 2, flip-flop stages on the remote pointer (legal >= 2)
IS_WRITE_SIDE, 1, 1 = full-side instance, 0 = empty-side instance
ALMOST_THRESH, 1, almost-flag margin in entries (0 .. 2^(n-1))

Ports:
clk  input  1  local domain clock, rising edge
rst_n  input  1  asynchronous active-low reset
remote_gptr  input  n  gray pointer from the other clock domain; asynchronous to clk
local_gnext  input  n  local counter's combinational next gray pointer (value the counter registers on this edge)
local_bnext  input  n  local counter's combinational next binary pointer
flag  output  1  registered full (write side) or empty (read side)
almost_flag  output  1  registered almost_full / almost_empty
level  output  n  registered: occupied entries (write side) or readable entries (read side)
remote_bsync  output  n  synchronised remote pointer, decoded to binary

Behaviour:
- Clocking and reset: one clock, clk, rising edge. Reset is asynchronous on rst_n falling and active low. Every register is in the clk domain.
- Reset values:
  - sync chain: all zeros
  - remote_bsync = 0, level = 0
  - write side: flag = 0, almost_flag = 0 (only if ALMOST_THRESH >= 2^(n-1) is almost_flag = 1)
  - read side: flag = 1, almost_flag = 1
- Synchroniser: remote_gptr passes through SYNC_STAGES flops, with no logic in between. The last stage is sync_g.
- Gray-to-binary decode:
  - combinational: b[n-1] = g[n-1]; b[i] = b[i+1] ^ g[i]
  - registered into remote_bsync
  - remote_bsync lags sync_g by one cycle, so the total remote latency is SYNC_STAGES+1 cycles.
- Flag, write side:
  - flag <= (local_gnext == {~sync_g[n-1:n-2], sync_g[n-3:0]})
  - for n == 2, compare against ~sync_g
- Flag, read side: flag <= (local_gnext == sync_g).
- Flag timing:
  - flags use the gray compare against sync_g, not remote_bsync, so they assert on the same edge the local pointer moves
  - deassertion is pessimistic by the sync latency
- Level, computed combinationally and registered, with modulo-2^n subtraction so wrap-around is free:
  - write side: level <= local_bnext - bin(sync_g)
  - read side: level <= bin(sync_g) - local_bnext
- Level range: it never exceeds 2^(n-1) for a correct FIFO. A value above 2^(n-1) is a protocol violation; the block does not clamp it.
- Almost flag:
  - write side: almost_flag <= (level_next >= 2^(n-1) - ALMOST_THRESH)
  - read side: almost_flag <= (level_next <= ALMOST_THRESH)
  - level_next is the value being registered into level.
- Consistency: flag set always implies almost_flag set.
- Simultaneous events: a remote pointer change and a local increment on the same edge need no special case. Both are folded into the same registered compare.
- Reset mid-operation: outputs go immediately to their reset values and the sync chain clears. The first valid remote value appears SYNC_STAGES cycles after rst_n rises. Both domains must be reset together; cross-domain reset release ordering is owned by the top level.
- No combinational path from any input to any output.

Test Plan:
- Reset, read side, n=4: assert rst_n=0 mid-run with remote_gptr=4'b0110 -> flag=1, almost_flag=1, level=0 asynchronously. After release, level=4 appears on the 3rd edge (SYNC_STAGES=2) with local_bnext=0.
- Write side fill to full, n=4: hold remote_gptr=0 and step local_bnext 0..8 -> level 0..8. flag=1 is registered on the edge where local_gnext=4'b1100. almost_flag (ALMOST_THRESH=1) sets at level=7.
- Read side drain to empty: remote held at binary 5 (gray 0111), local_bnext stepping 0..5 -> level 5..0. flag=1 on the edge local_gnext=0111. almost_flag sets at level=1.
- Wrap-around: write side with local_bnext=3, remote binary 11 (gray 1110) -> level=8 (3-11 mod 16), flag=1. Then remote advances to 12 -> level=7 and flag=0 after the 2-stage sync latency.
- Decode and latency: sweep remote_gptr through all 16 gray codes, one per 4 cycles -> remote_bsync equals the binary equivalent exactly SYNC_STAGES+1 edges later, every code checked.
- Simultaneous update, read side: remote and local both advance by one on the same edge while level=1 -> level stays 1 and flag stays 0. No glitch is observed on flag.

Source files
------------

// File: rtl/fifo_ptr_sync_status.sv
// Receiving side of the async FIFO gray-pointer crossing: synchronises the remote
// gray pointer and produces registered full/empty, almost flags and fill level.
module fifo_ptr_sync_status #(
  parameter int n             = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int IS_WRITE_SIDE = 1,
  parameter int ALMOST_THRESH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] remote_gptr,
  input  logic [n-1:0] local_gnext,
  input  logic [n-1:0] local_bnext,
  output logic         flag,
  output logic         almost_flag,
  output logic [n-1:0] level,
  output logic [n-1:0] remote_bsync
);

  localparam int DEPTH = 2 ** (n - 1);
  localparam logic [n:0] ALMOST_FULL_LIM = (n+1)'(DEPTH - ALMOST_THRESH);
  localparam logic [n:0] ALMOST_EMPTY_LIM = (n+1)'(ALMOST_THRESH);
  localparam logic FLAG_RST = (IS_WRITE_SIDE != 0) ? 1'b0 : 1'b1;
  localparam logic ALMOST_RST = (IS_WRITE_SIDE != 0) ? (ALMOST_THRESH >= DEPTH) : 1'b1;

  function automatic logic [n-1:0] gray2bin(input logic [n-1:0] g);
    logic [n-1:0] b;
    b[n-1] = g[n-1];
    for (int i = n - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [n-1:0] sync_q [SYNC_STAGES];
  logic [n-1:0] sync_g;
  logic [n-1:0] sync_b;
  logic [n-1:0] full_tgt;
  logic [n-1:0] level_d;
  logic         flag_d;
  logic         almost_d;
  logic         flag_q;
  logic         almost_q;
  logic [n-1:0] level_q;
  logic [n-1:0] bsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= remote_gptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign sync_g = sync_q[SYNC_STAGES-1];
  assign sync_b = gray2bin(sync_g);

  // Full when the local pointer is exactly one lap ahead: top two gray bits inverted.
  generate
    if (n == 2) begin : g_tgt_n2
      assign full_tgt = ~sync_g;
    end else begin : g_tgt_wide
      assign full_tgt = {~sync_g[n-1:n-2], sync_g[n-3:0]};
    end
  endgenerate

  always_comb begin
    flag_d   = 1'b0;
    level_d  = '0;
    almost_d = 1'b0;
    if (IS_WRITE_SIDE != 0) begin
      flag_d   = (local_gnext == full_tgt);
      level_d  = local_bnext - sync_b;
      almost_d = ({1'b0, level_d} >= ALMOST_FULL_LIM);
    end else begin
      flag_d   = (local_gnext == sync_g);
      level_d  = sync_b - local_bnext;
      almost_d = ({1'b0, level_d} <= ALMOST_EMPTY_LIM);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q   <= FLAG_RST;
      almost_q <= ALMOST_RST;
      level_q  <= '0;
      bsync_q  <= '0;
    end else begin
      flag_q   <= flag_d;
      almost_q <= almost_d;
      level_q  <= level_d;
      bsync_q  <= sync_b;
    end
  end

  assign flag         = flag_q;
  assign almost_flag  = almost_q;
  assign level        = level_q;
  assign remote_bsync = bsync_q;

endmodule

// File: tb/tb_fifo_ptr_sync_status.sv
// Directed bench for fifo_ptr_sync_status: one write-side and one read-side instance
// driven from a vector table plus hand-written latency, wrap and reset sequences.
module tb_fifo_ptr_sync_status;

  logic       clk;
  logic       rst_n;
  logic [3:0] w_remote, w_gnext, w_bnext;
  logic [3:0] r_remote, r_gnext, r_bnext;
  logic       w_flag, w_almost, r_flag, r_almost;
  logic [3:0] w_level, w_bsync, r_level, r_bsync;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_ptr_sync_status #(.n(4), .SYNC_STAGES(2), .IS_WRITE_SIDE(1), .ALMOST_THRESH(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .remote_gptr(w_remote), .local_gnext(w_gnext),
    .local_bnext(w_bnext), .flag(w_flag), .almost_flag(w_almost), .level(w_level),
    .remote_bsync(w_bsync)
  );

  fifo_ptr_sync_status #(.n(4), .SYNC_STAGES(2), .IS_WRITE_SIDE(0), .ALMOST_THRESH(1)) dut_r (
    .clk(clk), .rst_n(rst_n), .remote_gptr(r_remote), .local_gnext(r_gnext),
    .local_bnext(r_bnext), .flag(r_flag), .almost_flag(r_almost), .level(r_level),
    .remote_bsync(r_bsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         is_w;
    logic [3:0] r_bin;
    logic [3:0] l_bin;
    logic [3:0] exp_level;
    bit         exp_flag;
    bit         exp_almost;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [3:0] bin2gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [3:0] rb, input logic [3:0] lb);
    w_remote = bin2gray(rb);
    w_bnext  = lb;
    w_gnext  = bin2gray(lb);
  endtask

  task automatic set_r(input logic [3:0] rb, input logic [3:0] lb);
    r_remote = bin2gray(rb);
    r_bnext  = lb;
    r_gnext  = bin2gray(lb);
  endtask

  initial begin
    logic [3:0] prev_b;

    //          is_w  r   l  lvl f  a
    vecs[0]  = '{1'b1, 0,  0, 0, 0, 0};
    vecs[1]  = '{1'b1, 0,  5, 5, 0, 0};
    vecs[2]  = '{1'b1, 0,  7, 7, 0, 1};
    vecs[3]  = '{1'b1, 0,  8, 8, 1, 1};
    vecs[4]  = '{1'b1, 11, 3, 8, 1, 1};
    vecs[5]  = '{1'b1, 12, 3, 7, 0, 1};
    vecs[6]  = '{1'b1, 14, 15, 1, 0, 0};
    vecs[7]  = '{1'b0, 5,  0, 5, 0, 0};
    vecs[8]  = '{1'b0, 5,  4, 1, 0, 1};
    vecs[9]  = '{1'b0, 5,  5, 0, 1, 1};
    vecs[10] = '{1'b0, 2,  14, 4, 0, 0};
    vecs[11] = '{1'b0, 9,  9, 0, 1, 1};

    rst_n = 1'b0;
    set_w(0, 0);
    set_r(0, 0);
    #12;
    chk("rst_w_flag", w_flag, 0);
    chk("rst_w_almost", w_almost, 0);
    chk("rst_w_level", w_level, 0);
    chk("rst_r_flag", r_flag, 1);
    chk("rst_r_almost", r_almost, 1);
    chk("rst_r_bsync", r_bsync, 0);
    $display("reset state checked");
    rst_n = 1'b1;

    // Settled-state table: every vector held for SYNC_STAGES+2 edges
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].is_w) set_w(vecs[v].r_bin, vecs[v].l_bin);
      else              set_r(vecs[v].r_bin, vecs[v].l_bin);
      repeat (4) tick();
      if (vecs[v].is_w) begin
        chk("tbl_w_level", w_level, vecs[v].exp_level);
        chk("tbl_w_flag", w_flag, vecs[v].exp_flag);
        chk("tbl_w_almost", w_almost, vecs[v].exp_almost);
        chk("tbl_w_bsync", w_bsync, vecs[v].r_bin);
        $display("vec %0d write r=%0d l=%0d level=%0d flag=%0d almost=%0d",
                 v, vecs[v].r_bin, vecs[v].l_bin, w_level, w_flag, w_almost);
      end else begin
        chk("tbl_r_level", r_level, vecs[v].exp_level);
        chk("tbl_r_flag", r_flag, vecs[v].exp_flag);
        chk("tbl_r_almost", r_almost, vecs[v].exp_almost);
        chk("tbl_r_bsync", r_bsync, vecs[v].r_bin);
        $display("vec %0d read r=%0d l=%0d level=%0d flag=%0d almost=%0d",
                 v, vecs[v].r_bin, vecs[v].l_bin, r_level, r_flag, r_almost);
      end
    end

    // Write side fill: local pointer steps once per edge, flags follow on the same edge
    set_w(0, 0);
    repeat (4) tick();
    for (int k = 1; k <= 8; k++) begin
      set_w(0, 4'(k));
      tick();
      chk("fill_level", w_level, k);
      chk("fill_flag", w_flag, (k == 8));
      chk("fill_almost", w_almost, (k >= 7));
      $display("fill step %0d level=%0d flag=%0d almost=%0d", k, w_level, w_flag, w_almost);
    end

    // Read side drain from 5 entries down to empty
    set_r(5, 0);
    repeat (4) tick();
    chk("drain_start", r_level, 5);
    for (int k = 1; k <= 5; k++) begin
      set_r(5, 4'(k));
      tick();
      chk("drain_level", r_level, 5 - k);
      chk("drain_flag", r_flag, (k == 5));
      chk("drain_almost", r_almost, ((5 - k) <= 1));
      $display("drain step %0d level=%0d flag=%0d almost=%0d", k, r_level, r_flag, r_almost);
    end

    // Wrap-around full, then release after the sync latency
    set_w(11, 3);
    repeat (4) tick();
    chk("wrap_level", w_level, 8);
    chk("wrap_flag", w_flag, 1);
    set_w(12, 3);
    repeat (2) begin
      tick();
      chk("wrap_hold_level", w_level, 8);
      chk("wrap_hold_flag", w_flag, 1);
    end
    tick();
    chk("wrap_rel_level", w_level, 7);
    chk("wrap_rel_flag", w_flag, 0);
    $display("wrap release level=%0d flag=%0d", w_level, w_flag);

    // Decode sweep: each code must land in remote_bsync exactly 3 edges after it changes
    set_r(0, 0);
    repeat (4) tick();
    prev_b = 4'd0;
    for (int c = 0; c < 16; c++) begin
      r_remote = bin2gray(4'(c));
      tick();
      tick();
      chk("dec_early", r_bsync, prev_b);
      tick();
      chk("dec_value", r_bsync, c);
      $display("decode gray=%b bsync=%0d", bin2gray(4'(c)), r_bsync);
      tick();
      prev_b = 4'(c);
    end

    // Asynchronous reset mid-run with a live remote pointer
    r_remote = 4'b0110;
    r_bnext  = 4'd0;
    r_gnext  = 4'd0;
    repeat (4) tick();
    chk("prerst_level", r_level, 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flag", r_flag, 1);
    chk("arst_almost", r_almost, 1);
    chk("arst_level", r_level, 0);
    chk("arst_bsync", r_bsync, 0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    chk("rel_level_e2", r_level, 0);
    tick();
    chk("rel_level_e3", r_level, 4);
    $display("reset release level=%0d", r_level);

    // Simultaneous update: synced remote and local pointer advance on the same edge
    set_r(6, 5);
    repeat (4) tick();
    chk("sim_start_level", r_level, 1);
    r_remote = bin2gray(4'd7);
    for (int e = 0; e < 4; e++) begin
      tick();
      if (e == 1) begin
        r_bnext = 4'd6;
        r_gnext = bin2gray(4'd6);
      end
      chk("sim_level", r_level, 1);
      chk("sim_flag", r_flag, 0);
      $display("simultaneous edge %0d level=%0d flag=%0d", e, r_level, r_flag);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
